// File: rtl/axi_weight_write_serializer_if.sv
// ---------------------------------------------------------------------------
// axi_weight_write_serializer_if
// AXI-lite style write-beat channel feeding the weight write serializer.
//   axi_wr_data   : beat data, lane i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   axi_wr_addr   : beat byte address
//   axi_wr_strobe : byte strobes, one per data byte
//   axi_wr_en     : beat valid
//   axi_wr_ready  : beat accepted when axi_wr_en & axi_wr_ready
// master = write decoder side, slave = serializer side.
// ---------------------------------------------------------------------------
interface axi_weight_write_serializer_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_DATA_WIDTH-1:0]   axi_wr_data;
    logic [AXI_ADDR_WIDTH-1:0]   axi_wr_addr;
    logic [AXI_DATA_WIDTH/8-1:0] axi_wr_strobe;
    logic                        axi_wr_en;
    logic                        axi_wr_ready;

    modport master (
        output axi_wr_data, axi_wr_addr, axi_wr_strobe, axi_wr_en,
        input  axi_wr_ready
    );

    modport slave (
        input  axi_wr_data, axi_wr_addr, axi_wr_strobe, axi_wr_en,
        output axi_wr_ready
    );
endinterface

// File: rtl/axi_weight_write_serializer.sv
// ---------------------------------------------------------------------------
// axi_weight_write_serializer
// Accepts write beats carrying L = AXI_DATA_WIDTH/WEIGHT_WIDTH packed weights,
// queues the valid lanes of each beat in a small FIFO and emits one weight
// write per cycle (ascending lane order, beat order preserved).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   axi          : write-beat channel (slave modport)
//   weight_data  : registered weight value
//   weight_addr  : registered weight index
//   weight_we    : registered write enable, one weight per cycle
//   busy         : FIFO non-empty, lanes pending, or a write on the outputs
//   err_flags    : sticky, [0] partial-lane strobe, [1] write while not ready
//   err_clear    : synchronous clear of err_flags (wins over a new error)
// ---------------------------------------------------------------------------
module axi_weight_write_serializer #(
    parameter int NUM_WEIGHTS    = 76976,
    parameter int WEIGHT_WIDTH   = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_BASE_ADDR  = 393732,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axi_weight_write_serializer_if.slave  axi,
    output logic [WEIGHT_WIDTH-1:0]       weight_data,
    output logic [31:0]                   weight_addr,
    output logic                          weight_we,
    output logic                          busy,
    output logic [1:0]                    err_flags,
    input  logic                          err_clear
);
    localparam int L     = AXI_DATA_WIDTH / WEIGHT_WIDTH;
    localparam int WB    = WEIGHT_WIDTH / 8;
    localparam int SHIFT = $clog2(AXI_DATA_WIDTH / 8);
    localparam int LIW   = (L > 1) ? $clog2(L) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] BASE_A = AXI_ADDR_WIDTH'(AXI_BASE_ADDR);

    typedef enum logic [0:0] {IDLE, EMIT} state_t;

    // ---------------- beat decode ----------------
    logic                      addr_in_base;
    logic [AXI_ADDR_WIDTH-1:0] off;
    logic [63:0]               base_wide;   // wide so the range test cannot wrap
    logic [L-1:0]              lane_mask;
    logic [L-1:0]              lane_partial;

    assign addr_in_base = axi.axi_wr_addr >= BASE_A;
    assign off          = axi.axi_wr_addr - BASE_A;
    assign base_wide    = (64'(off) >> SHIFT) * 64'(L);

    // ---------------- FIFO / handshake ----------------
    logic [AXI_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [31:0]               fifo_base [FIFO_DEPTH];
    logic [L-1:0]              fifo_mask [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]             count_reg;
    logic                      full, accept, push, pop, fifo_nonempty;

    assign full             = count_reg == CW'(FIFO_DEPTH);
    assign fifo_nonempty    = count_reg != '0;
    assign axi.axi_wr_ready = !full;
    assign accept           = axi.axi_wr_en && !full;
    assign push             = accept && (|lane_mask);

    // ---------------- serializer state ----------------
    state_t                    state_reg;
    logic [AXI_DATA_WIDTH-1:0] cur_data_reg;
    logic [31:0]               cur_base_reg;
    logic [L-1:0]              rem_mask_reg;

    // In IDLE the lane select works straight off the FIFO head so a popped
    // beat emits its first lane on the popping edge; in EMIT it works off the
    // beat held in cur_*_reg.
    logic [AXI_DATA_WIDTH-1:0] sel_data;
    logic [31:0]               sel_base;
    logic [L-1:0]              sel_mask, sel_onehot, sel_rest;
    logic [LIW-1:0]            sel_idx;
    logic [WEIGHT_WIDTH-1:0]   sel_lanes [L];

    assign sel_data   = (state_reg == IDLE) ? fifo_data[rd_ptr_reg] : cur_data_reg;
    assign sel_base   = (state_reg == IDLE) ? fifo_base[rd_ptr_reg] : cur_base_reg;
    assign sel_mask   = (state_reg == IDLE) ? fifo_mask[rd_ptr_reg] : rem_mask_reg;
    assign sel_onehot = sel_mask & (~sel_mask + 1'b1);
    assign sel_rest   = sel_mask & ~sel_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_lane
            logic [WB-1:0] stb;
            logic          in_range;
            assign stb               = axi.axi_wr_strobe[gi*WB +: WB];
            assign in_range          = addr_in_base && ((base_wide + 64'(gi)) < 64'(NUM_WEIGHTS));
            assign lane_mask[gi]     = in_range && (&stb);
            assign lane_partial[gi]  = in_range && (|stb) && !(&stb);
            assign sel_lanes[gi]     = sel_data[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    endgenerate

    always_comb begin
        sel_idx = '0;
        for (int i = L - 1; i >= 0; i--) begin
            if (sel_mask[i]) sel_idx = LIW'(i);
        end
    end

    // IDLE always pops a non-empty FIFO; EMIT pops on the edge that emits
    // the last pending lane so the next beat follows without a bubble.
    assign pop = fifo_nonempty && ((state_reg == IDLE) || (sel_rest == '0));

    // Storage carries no reset: contents are only meaningful under count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= axi.axi_wr_data;
            fifo_base[wr_ptr_reg] <= base_wide[31:0];
            fifo_mask[wr_ptr_reg] <= lane_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            weight_we    <= 1'b0;
            weight_data  <= '0;
            weight_addr  <= '0;
            cur_data_reg <= '0;
            cur_base_reg <= '0;
            rem_mask_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fifo_nonempty) begin
                        weight_we    <= 1'b1;
                        weight_data  <= sel_lanes[sel_idx];
                        weight_addr  <= sel_base + 32'(sel_idx);
                        cur_data_reg <= sel_data;
                        cur_base_reg <= sel_base;
                        rem_mask_reg <= sel_rest;
                        state_reg    <= (sel_rest != '0) ? EMIT : IDLE;
                    end else begin
                        weight_we <= 1'b0;
                    end
                end
                EMIT: begin
                    weight_we   <= 1'b1;
                    weight_data <= sel_lanes[sel_idx];
                    weight_addr <= sel_base + 32'(sel_idx);
                    if (sel_rest != '0) begin
                        rem_mask_reg <= sel_rest;
                    end else if (fifo_nonempty) begin
                        cur_data_reg <= fifo_data[rd_ptr_reg];
                        cur_base_reg <= fifo_base[rd_ptr_reg];
                        rem_mask_reg <= fifo_mask[rd_ptr_reg];
                    end else begin
                        rem_mask_reg <= '0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ---------------- sticky errors ----------------
    logic err_partial, err_drop;
    assign err_partial = accept && (|lane_partial);
    assign err_drop    = axi.axi_wr_en && full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags <= 2'b00;
        end else if (err_clear) begin
            err_flags <= 2'b00;
        end else begin
            err_flags <= err_flags | {err_drop, err_partial};
        end
    end

    assign busy = fifo_nonempty || (state_reg == EMIT) || weight_we;
endmodule

// File: tb/tb_axi_weight_write_serializer.sv
// ---------------------------------------------------------------------------
// tb_axi_weight_write_serializer
// Directed bench for the weight write serializer: instance A uses the default
// parameters (16-bit weights, 32-bit beats), instance B uses 8-bit weights on
// 64-bit beats with a 64-bit aligned base address.
// ---------------------------------------------------------------------------
module tb_axi_weight_write_serializer;
    localparam int BASE_A = 393732;
    localparam int BASE_B = 393728;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    axi_weight_write_serializer_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) bus_a ();
    logic [15:0] data_a;
    logic [31:0] addr_a;
    logic        we_a, busy_a, err_clear_a;
    logic [1:0]  err_a;

    axi_weight_write_serializer dut_a (
        .clk(clk), .rst_n(rst_n), .axi(bus_a),
        .weight_data(data_a), .weight_addr(addr_a), .weight_we(we_a),
        .busy(busy_a), .err_flags(err_a), .err_clear(err_clear_a)
    );

    // ---------------- instance B ----------------
    axi_weight_write_serializer_if #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32)) bus_b ();
    logic [7:0]  data_b;
    logic [31:0] addr_b;
    logic        we_b, busy_b, err_clear_b;
    logic [1:0]  err_b;

    axi_weight_write_serializer #(
        .WEIGHT_WIDTH(8), .AXI_DATA_WIDTH(64), .AXI_BASE_ADDR(BASE_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .axi(bus_b),
        .weight_data(data_b), .weight_addr(addr_b), .weight_we(we_b),
        .busy(busy_b), .err_flags(err_b), .err_clear(err_clear_b)
    );

    // ---------------- write monitors ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t q_a[$];
    wr_t q_b[$];

    always @(negedge clk) begin
        if (we_a === 1'b1) q_a.push_back({32'(cyc), addr_a, 32'(data_a)});
        if (we_b === 1'b1) q_b.push_back({32'(cyc), addr_b, 32'(data_b)});
    end

    // ---------------- drivers ----------------
    task automatic beat_a(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int acc);
        @(negedge clk);
        bus_a.axi_wr_addr = addr; bus_a.axi_wr_data = data;
        bus_a.axi_wr_strobe = strb; bus_a.axi_wr_en = 1'b1;
        @(negedge clk);
        acc = cyc;
        bus_a.axi_wr_en = 1'b0;
    endtask

    task automatic beat_b(input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, output int acc);
        @(negedge clk);
        bus_b.axi_wr_addr = addr; bus_b.axi_wr_data = data;
        bus_b.axi_wr_strobe = strb; bus_b.axi_wr_en = 1'b1;
        @(negedge clk);
        acc = cyc;
        bus_b.axi_wr_en = 1'b0;
    endtask

    task automatic wait_idle_a(input int max);
        int n = 0;
        @(negedge clk);
        while (busy_a !== 1'b0 && n < max) begin @(negedge clk); n++; end
        if (n >= max) begin
            checks++; failures++;
            $display("FAIL idle_timeout_a busy=%0b after %0d cycles", busy_a, n);
        end
    endtask

    task automatic wait_idle_b(input int max);
        int n = 0;
        @(negedge clk);
        while (busy_b !== 1'b0 && n < max) begin @(negedge clk); n++; end
        if (n >= max) begin
            checks++; failures++;
            $display("FAIL idle_timeout_b busy=%0b after %0d cycles", busy_b, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++; if (we_a !== 1'b0)   begin failures++; $display("FAIL reset_we got=%b exp=0", we_a); end
        checks++; if (data_a !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_a); end
        checks++; if (addr_a !== 32'h0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr_a); end
        checks++; if (err_a !== 2'b00)  begin failures++; $display("FAIL reset_err got=%b exp=00", err_a); end
        checks++; if (busy_a !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (we_b !== 1'b0)   begin failures++; $display("FAIL reset_we_b got=%b exp=0", we_b); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (bus_a.axi_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus_a.axi_wr_ready); end
        checks++; if (bus_b.axi_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_b got=%b exp=1", bus_b.axi_wr_ready); end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_basic();
        int acc;
        q_a.delete();
        beat_a(32'(BASE_A), 32'hBEEF1234, 4'hF, acc);
        wait_idle_a(20);
        checks++; if (q_a.size() != 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", q_a.size()); end
        if (q_a.size() >= 2) begin
            checks++; if (q_a[0].addr !== 32'd0 || q_a[0].data !== 32'h1234)
                begin failures++; $display("FAIL basic_w0 got=%0d/%h exp=0/1234", q_a[0].addr, q_a[0].data); end
            checks++; if (q_a[1].addr !== 32'd1 || q_a[1].data !== 32'hBEEF)
                begin failures++; $display("FAIL basic_w1 got=%0d/%h exp=1/beef", q_a[1].addr, q_a[1].data); end
            checks++; if (q_a[0].cyc !== 32'(acc + 1))
                begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", q_a[0].cyc, acc + 1); end
            checks++; if (q_a[1].cyc !== 32'(acc + 2))
                begin failures++; $display("FAIL basic_second got=%0d exp=%0d", q_a[1].cyc, acc + 2); end
        end
        checks++; if (we_a !== 1'b0) begin failures++; $display("FAIL basic_we_low got=%b exp=0", we_a); end
        $display("test_basic done checks=%0d", checks);
    endtask

    task automatic test_strobe();
        int acc;
        q_a.delete();
        beat_a(32'(BASE_A + 8), 32'hCAFE5555, 4'hC, acc);
        wait_idle_a(20);
        checks++; if (q_a.size() != 1) begin failures++; $display("FAIL strobe_hi_count got=%0d exp=1", q_a.size()); end
        if (q_a.size() >= 1) begin
            checks++; if (q_a[0].addr !== 32'd5 || q_a[0].data !== 32'hCAFE)
                begin failures++; $display("FAIL strobe_hi got=%0d/%h exp=5/cafe", q_a[0].addr, q_a[0].data); end
        end
        q_a.delete();
        beat_a(32'(BASE_A + 8), 32'h12345678, 4'h6, acc);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL strobe_part_busy got=%b exp=0", busy_a); end
        repeat (3) @(negedge clk);
        checks++; if (q_a.size() != 0) begin failures++; $display("FAIL strobe_part_write got=%0d exp=0", q_a.size()); end
        checks++; if (err_a !== 2'b01) begin failures++; $display("FAIL strobe_part_err got=%b exp=01", err_a); end
        err_clear_a = 1'b1;
        @(negedge clk);
        err_clear_a = 1'b0;
        checks++; if (err_a !== 2'b00) begin failures++; $display("FAIL err_clear got=%b exp=00", err_a); end
        // clear and a fresh partial error on the same edge: clear wins
        bus_a.axi_wr_addr = 32'(BASE_A + 8); bus_a.axi_wr_strobe = 4'h6;
        bus_a.axi_wr_en = 1'b1; err_clear_a = 1'b1;
        @(negedge clk);
        bus_a.axi_wr_en = 1'b0; err_clear_a = 1'b0;
        checks++; if (err_a !== 2'b00) begin failures++; $display("FAIL err_clear_prio got=%b exp=00", err_a); end
        $display("test_strobe done checks=%0d", checks);
    endtask

    task automatic test_bounds();
        int acc;
        q_a.delete();
        beat_a(32'(BASE_A + 153948), 32'h0B0BA0A0, 4'hF, acc);
        wait_idle_a(20);
        checks++; if (q_a.size() != 2) begin failures++; $display("FAIL bound_last_count got=%0d exp=2", q_a.size()); end
        if (q_a.size() >= 2) begin
            checks++; if (q_a[0].addr !== 32'd76974 || q_a[0].data !== 32'hA0A0)
                begin failures++; $display("FAIL bound_last0 got=%0d/%h exp=76974/a0a0", q_a[0].addr, q_a[0].data); end
            checks++; if (q_a[1].addr !== 32'd76975 || q_a[1].data !== 32'h0B0B)
                begin failures++; $display("FAIL bound_last1 got=%0d/%h exp=76975/0b0b", q_a[1].addr, q_a[1].data); end
        end
        q_a.delete();
        beat_a(32'(BASE_A + 153952), 32'h11112222, 4'hF, acc);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL bound_above_busy got=%b exp=0", busy_a); end
        beat_a(32'(BASE_A - 4), 32'h33334444, 4'hF, acc);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL bound_below_busy got=%b exp=0", busy_a); end
        repeat (3) @(negedge clk);
        checks++; if (q_a.size() != 0) begin failures++; $display("FAIL bound_out_write got=%0d exp=0", q_a.size()); end
        checks++; if (err_a !== 2'b00) begin failures++; $display("FAIL bound_out_err got=%b exp=00", err_a); end
        $display("test_bounds done checks=%0d", checks);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [15:0] lo;
        q_a.delete();
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            lo = 16'(16'h1000 + 2 * b);
            bus_a.axi_wr_addr = 32'(BASE_A + 4 * b);
            bus_a.axi_wr_data = {lo + 16'd1, lo};
            bus_a.axi_wr_strobe = 4'hF;
            bus_a.axi_wr_en = 1'b1;
            n = 0;
            while (bus_a.axi_wr_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        checks++; if (bus_a.axi_wr_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", bus_a.axi_wr_ready); end
        // beat driven while not ready must be dropped and flagged
        bus_a.axi_wr_addr = 32'(BASE_A + 32);
        bus_a.axi_wr_data = 32'hDEADDEAD;
        @(negedge clk);
        bus_a.axi_wr_en = 1'b0;
        checks++; if (err_a !== 2'b10) begin failures++; $display("FAIL b2b_drop_err got=%b exp=10", err_a); end
        wait_idle_a(60);
        checks++; if (q_a.size() != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", q_a.size()); end
        if (q_a.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (q_a[i].addr !== 32'(i) || q_a[i].data !== 32'(16'h1000 + i) || q_a[i].cyc !== q_a[0].cyc + 32'(i)) begin
                    failures++;
                    $display("FAIL b2b_w%0d got=%0d/%h@%0d exp=%0d/%h@%0d", i, q_a[i].addr, q_a[i].data,
                             q_a[i].cyc, i, 16'h1000 + i, q_a[0].cyc + 32'(i));
                end
            end
        end
        err_clear_a = 1'b1;
        @(negedge clk);
        err_clear_a = 1'b0;
        $display("test_back_to_back done checks=%0d", checks);
    endtask

    task automatic test_wide();
        int acc;
        q_b.delete();
        beat_b(32'(BASE_B), 64'h8877665544332211, 8'hFF, acc);
        wait_idle_b(30);
        checks++; if (q_b.size() != 8) begin failures++; $display("FAIL wide_full_count got=%0d exp=8", q_b.size()); end
        if (q_b.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (q_b[i].addr !== 32'(i) || q_b[i].data !== 32'(8'h11 * (i + 1)) || q_b[i].cyc !== 32'(acc + 1 + i)) begin
                    failures++;
                    $display("FAIL wide_w%0d got=%0d/%h@%0d exp=%0d/%h@%0d", i, q_b[i].addr, q_b[i].data,
                             q_b[i].cyc, i, 8'h11 * (i + 1), acc + 1 + i);
                end
            end
        end
        q_b.delete();
        beat_b(32'(BASE_B), 64'h7F00000000000042, 8'h81, acc);
        wait_idle_b(30);
        checks++; if (q_b.size() != 2) begin failures++; $display("FAIL wide_sparse_count got=%0d exp=2", q_b.size()); end
        if (q_b.size() >= 2) begin
            checks++; if (q_b[0].addr !== 32'd0 || q_b[0].data !== 32'h42 || q_b[0].cyc !== 32'(acc + 1))
                begin failures++; $display("FAIL wide_sparse0 got=%0d/%h@%0d exp=0/42@%0d", q_b[0].addr, q_b[0].data, q_b[0].cyc, acc + 1); end
            checks++; if (q_b[1].addr !== 32'd7 || q_b[1].data !== 32'h7F || q_b[1].cyc !== 32'(acc + 2))
                begin failures++; $display("FAIL wide_sparse1 got=%0d/%h@%0d exp=7/7f@%0d", q_b[1].addr, q_b[1].data, q_b[1].cyc, acc + 2); end
        end
        $display("test_wide done checks=%0d", checks);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            bus_a.axi_wr_addr = 32'(BASE_A + 4 * b);
            bus_a.axi_wr_data = 32'(32'h20002000 + b);
            bus_a.axi_wr_strobe = 4'hF;
            bus_a.axi_wr_en = 1'b1;
            @(negedge clk);
        end
        bus_a.axi_wr_en = 1'b0;
        checks++; if (we_a !== 1'b1) begin failures++; $display("FAIL rstmid_active got=%b exp=1", we_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (we_a !== 1'b0)   begin failures++; $display("FAIL rstmid_we got=%b exp=0", we_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        q_a.delete();
        repeat (10) @(negedge clk);
        checks++; if (q_a.size() != 0) begin failures++; $display("FAIL rstmid_residual got=%0d exp=0", q_a.size()); end
        checks++; if (bus_a.axi_wr_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus_a.axi_wr_ready); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b exp=0", busy_a); end
        $display("test_reset_mid done checks=%0d", checks);
    endtask

    initial begin
        bus_a.axi_wr_data = '0; bus_a.axi_wr_addr = '0; bus_a.axi_wr_strobe = '0; bus_a.axi_wr_en = 1'b0;
        bus_b.axi_wr_data = '0; bus_b.axi_wr_addr = '0; bus_b.axi_wr_strobe = '0; bus_b.axi_wr_en = 1'b0;
        err_clear_a = 1'b0;
        err_clear_b = 1'b0;
        test_reset();
        test_basic();
        test_strobe();
        test_bounds();
        test_back_to_back();
        test_wide();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
